// File: rtl/store_unit_pkg.sv
// store_unit_pkg: store opcodes, FSM state type and timeout counter width.
package store_unit_pkg;
    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2B;
    localparam int TMO_W = 8;
    typedef enum logic {ST_IDLE, ST_REQ} state_t;
endpackage

// File: rtl/store_lane_fmt.sv
// store_lane_fmt: narrows store data, replicates it onto byte lanes and
// derives byte enables and alignment legality.
module store_lane_fmt
    import store_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [5:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        legal
);
    logic is_sb, is_sh, is_sw;
    logic [3:0] be_sb, be_sh;
    always_comb begin
        is_sb = op == OP_SB;
        is_sh = op == OP_SH;
        is_sw = op == OP_SW;
        wdata = is_sb ? {4{data[7:0]}} : is_sh ? {2{data[15:0]}} : data;
        be_sb = BIG_ENDIAN ? 4'b1000 >> addr : 4'b0001 << addr;
        be_sh = (addr[1] ^ !BIG_ENDIAN) ? 4'b0011 : 4'b1100;
        be    = is_sb ? be_sb : is_sh ? be_sh : is_sw ? 4'b1111 : 4'b0000;
        legal = is_sb | (is_sh & !addr[0]) | (is_sw & (addr == 2'b00));
    end
endmodule

// File: rtl/store_unit.sv
// store_unit: accepts one store, drives it on a req/ack memory port and
// stalls the pipeline until ack or timeout.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [5:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        misalign,
    output logic        bus_err
);
    localparam logic [TMO_W-1:0] LAST = TMO_W'(ACK_TIMEOUT - 1);
    state_t state;
    logic [TMO_W-1:0] cnt;
    logic [31:0] f_wdata;
    logic [3:0] f_be;
    logic f_legal;
    store_lane_fmt #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
        .op(st_op), .addr(st_addr[1:0]), .data(st_data),
        .wdata(f_wdata), .be(f_be), .legal(f_legal)
    );
    assign st_ready = state == ST_IDLE;
    assign stall    = state != ST_IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            if (state == ST_IDLE) begin
                if (st_valid && f_legal) begin
                    state     <= ST_REQ;
                    cnt       <= '0;
                    mem_req   <= 1'b1;
                    mem_addr  <= {st_addr[31:2], 2'b00};
                    mem_wdata <= f_wdata;
                    mem_be    <= f_be;
                end else if (st_valid) begin
                    misalign <= 1'b1;
                end
            end else if (mem_ack) begin
                state   <= ST_IDLE;
                mem_req <= 1'b0;
            end else if (cnt == LAST) begin
                // an ack arriving in the expiry cycle is handled above and wins
                state   <= ST_IDLE;
                mem_req <= 1'b0;
                bus_err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
